// File: rtl/a2d_scan_sched_if.sv
// A2D conversion handshake bundle between the scan scheduler and the SPI A2D interface.
// Latency: none, wires only.
// Backpressure: none; the scheduler issues one start and then waits for the sticky completion.
// Ports: strt_cnv (start pulse), chnnl (channel), cnv_cmplt (sticky done), res (12-bit result).
interface a2d_scan_sched_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    // master: scheduler side, slave: A2D interface side
    modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
    modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/a2d_scan_sched.sv
// Periodic masked scan of 8 A2D channels into a result file, plus one prioritised demand requester.
// Latency: strt_cnv 2 clks after req is sampled in IDLE; ack 2 clks after the completion rising edge.
// Backpressure: one conversion in flight; req is held until ack; timer wraps during a busy scan raise overrun.
// Ports: clk/rst_n; en, ch_mask (scan control); req/req_ch/ack/dmd_res (demand);
//        rd_ch/rd_res/valid (result file); scan_done, overrun, err (status); a2d (conversion handshake).
module a2d_scan_sched #(
    parameter int PERIOD  = 50000,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  ch_mask,
    input  logic        req,
    input  logic [2:0]  req_ch,
    output logic        ack,
    output logic [11:0] dmd_res,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_res,
    output logic [7:0]  valid,
    output logic        scan_done,
    output logic        overrun,
    output logic        err,
    a2d_scan_sched_if.master a2d
);

    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(PERIOD - 1);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

    state_t      state;
    logic [TW-1:0] timer;
    logic [WW-1:0] wdog;
    logic        scan_pend;
    logic        scan_act;     // a scan is in progress (survives demand interruptions)
    logic [7:0]  scan_mask;    // channels still to convert in the current scan
    logic        dmd;          // conversion in flight belongs to the demand requester
    logic        cnv_cmplt_q;
    logic        strt_cnv_r;
    logic [2:0]  chnnl_r;
    logic [11:0] res_mem [8];

    logic        cmplt;
    logic        req_ok;
    logic [7:0]  store_mask;
    logic        scan_busy;
    logic        timer_wrap;

    function automatic logic [2:0] low_bit(input logic [7:0] m);
        low_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) low_bit = 3'(i);
        end
    endfunction

    always_comb begin
        cmplt      = a2d.cnv_cmplt & ~cnv_cmplt_q;
        // The request being stored or acknowledged right now is still held high;
        // it must not be served a second time.
        req_ok     = req & ~ack & ~((state == STORE) & dmd);
        store_mask = dmd ? scan_mask : (scan_mask & ~(8'd1 << chnnl_r));
        // A scan finishing this cycle no longer counts as busy, so a coincident wrap queues the next one.
        scan_busy  = scan_act & ~((state == STORE) & ~req_ok & (store_mask == 8'd0));
        timer_wrap = en & (timer == T_LAST);
    end

    assign a2d.strt_cnv = strt_cnv_r;
    assign a2d.chnnl    = chnnl_r;
    assign rd_res       = res_mem[rd_ch];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            wdog        <= '0;
            scan_pend   <= 1'b0;
            scan_act    <= 1'b0;
            scan_mask   <= 8'd0;
            dmd         <= 1'b0;
            cnv_cmplt_q <= 1'b0;
            strt_cnv_r  <= 1'b0;
            chnnl_r     <= 3'd0;
            ack         <= 1'b0;
            dmd_res     <= 12'd0;
            valid       <= 8'd0;
            scan_done   <= 1'b0;
            overrun     <= 1'b0;
            err         <= 1'b0;
            for (int i = 0; i < 8; i++) res_mem[i] <= 12'd0;
        end else begin
            ack         <= 1'b0;
            strt_cnv_r  <= 1'b0;
            scan_done   <= 1'b0;
            overrun     <= 1'b0;
            cnv_cmplt_q <= a2d.cnv_cmplt;

            if (!en) begin
                timer     <= '0;
                scan_pend <= 1'b0;
            end else if (timer_wrap) begin
                timer <= '0;
                if (scan_pend || scan_busy) overrun   <= 1'b1;
                else                        scan_pend <= 1'b1;
            end else begin
                timer <= timer + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (req_ok) begin
                        chnnl_r <= req_ch;
                        dmd     <= 1'b1;
                        state   <= START;
                    end else if (scan_pend && en) begin
                        scan_pend <= 1'b0;
                        scan_mask <= ch_mask;
                        // An empty mask consumes the trigger without starting anything.
                        if (ch_mask != 8'd0) begin
                            chnnl_r  <= low_bit(ch_mask);
                            dmd      <= 1'b0;
                            scan_act <= 1'b1;
                            state    <= START;
                        end
                    end
                end
                START: begin
                    strt_cnv_r <= 1'b1;
                    wdog       <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (cmplt) begin
                        state <= STORE;
                    end else if (wdog == W_LAST) begin
                        // Abandon the conversion and the whole scan; a held demand is retried from IDLE.
                        err       <= 1'b1;
                        scan_act  <= 1'b0;
                        scan_mask <= 8'd0;
                        state     <= IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                STORE: begin
                    if (dmd) begin
                        dmd_res <= a2d.res;
                        ack     <= 1'b1;
                    end else begin
                        res_mem[chnnl_r] <= a2d.res;
                        valid[chnnl_r]   <= 1'b1;
                    end
                    scan_mask <= store_mask;
                    if (req_ok) begin
                        chnnl_r <= req_ch;
                        dmd     <= 1'b1;
                        state   <= START;
                    end else if (store_mask != 8'd0) begin
                        chnnl_r <= low_bit(store_mask);
                        dmd     <= 1'b0;
                        state   <= START;
                    end else begin
                        if (scan_act) scan_done <= 1'b1;
                        scan_act <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_scan_sched.sv
// Directed bench: an A2D model answers res = 0x100 + channel 40 clks after each start.
// Expected channel starts and demand results are queued at stimulus time; a negedge monitor
// pops and compares them as the DUT emits strt_cnv and ack.
module tb_a2d_scan_sched;
    localparam int PERIOD  = 100;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  ch_mask = 8'd0;
    logic        req = 1'b0;
    logic [2:0]  req_ch = 3'd0;
    logic [2:0]  rd_ch = 3'd0;
    logic        ack;
    logic [11:0] dmd_res;
    logic [11:0] rd_res;
    logic [7:0]  valid;
    logic        scan_done;
    logic        overrun;
    logic        err;

    a2d_scan_sched_if a2d();

    a2d_scan_sched #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
        .req(req), .req_ch(req_ch), .ack(ack), .dmd_res(dmd_res),
        .rd_ch(rd_ch), .rd_res(rd_res), .valid(valid),
        .scan_done(scan_done), .overrun(overrun), .err(err),
        .a2d(a2d)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // ---------------- A2D model ----------------
    logic hang = 1'b0;
    int   cnt = 0;
    logic [2:0] m_ch = 3'd0;
    initial begin
        a2d.cnv_cmplt = 1'b0;
        a2d.res = 12'd0;
        forever begin
            @(negedge clk);
            if (a2d.strt_cnv) begin
                a2d.cnv_cmplt = 1'b0;
                cnt = 40;
                m_ch = a2d.chnnl;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !hang) begin
                    a2d.res = 12'h100 + {9'd0, m_ch};
                    a2d.cnv_cmplt = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [2:0]  exp_ch[$];
    logic [11:0] exp_dmd[$];
    int cyc = 0;
    int strt_cnt = 0, sd_cnt = 0, ovr_cnt = 0, ack_cnt = 0;
    int prev_sd_cyc = 0, last_sd_cyc = 0;
    logic [2:0] last_strt_ch = 3'd0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (a2d.strt_cnv) begin
            strt_cnt++;
            last_strt_ch = a2d.chnnl;
            if (exp_ch.size() == 0) begin
                total++;
                $display("FAIL strt_unexpected: actual ch %0d required no start", a2d.chnnl);
            end else begin
                chk("strt_ch", 32'(a2d.chnnl), 32'(exp_ch.pop_front()));
            end
        end
        if (ack) begin
            ack_cnt++;
            if (exp_dmd.size() == 0) begin
                total++;
                $display("FAIL ack_unexpected: actual dmd_res %0h required no ack", dmd_res);
            end else begin
                chk("dmd_res", 32'(dmd_res), 32'(exp_dmd.pop_front()));
            end
        end
        if (scan_done) begin
            sd_cnt++;
            prev_sd_cyc = last_sd_cyc;
            last_sd_cyc = cyc;
        end
        if (overrun) ovr_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic wait_sd(input int target, input int bound, input string name);
        for (int i = 0; i < bound && sd_cnt < target; i++) @(negedge clk);
        chk(name, 32'(sd_cnt >= target), 32'd1);
    endtask

    task automatic wait_ack_drop(input int bound, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = ack;
        end
        req = 1'b0;
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_strt_now(input int bound, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = a2d.strt_cnv;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic read_chk(input logic [2:0] ch, input logic [11:0] exp, input string name);
        rd_ch = ch;
        #1;
        chk(name, 32'(rd_res), 32'(exp));
    endtask

    task automatic check_zero(input string tag);
        rd_ch = 3'd0;
        #1;
        chk({tag, "_ack"},       32'(ack),        32'd0);
        chk({tag, "_strt"},      32'(a2d.strt_cnv), 32'd0);
        chk({tag, "_scan_done"}, 32'(scan_done),  32'd0);
        chk({tag, "_overrun"},   32'(overrun),    32'd0);
        chk({tag, "_err"},       32'(err),        32'd0);
        chk({tag, "_valid"},     32'(valid),      32'd0);
        chk({tag, "_dmd_res"},   32'(dmd_res),    32'd0);
        chk({tag, "_chnnl"},     32'(a2d.chnnl),  32'd0);
        chk({tag, "_rd_res"},    32'(rd_res),     32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "global timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, base, ov0, st0, ak0, early;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Periodic scan of ch0 and ch2
        ch_mask = 8'h05;
        repeat (3) begin
            exp_ch.push_back(3'd0);
            exp_ch.push_back(3'd2);
        end
        en = 1'b1;
        wait_sd(3, 500, "scan3_done");
        en = 1'b0;
        chk("sd_period", 32'(last_sd_cyc - prev_sd_cyc), 32'd100);
        chk("scan_q_empty", 32'(exp_ch.size()), 32'd0);
        chk("valid_05", 32'(valid), 32'h05);
        read_chk(3'd2, 12'h102, "rd_ch2");
        read_chk(3'd0, 12'h100, "rd_ch0");
        read_chk(3'd1, 12'h000, "rd_ch1_empty");
        chk("no_overrun_scan", 32'(ovr_cnt), 32'd0);

        // Demand conversion from IDLE
        repeat (2) @(negedge clk);
        exp_ch.push_back(3'd5);
        exp_dmd.push_back(12'h105);
        @(posedge clk);
        #1;
        req_ch = 3'd5;
        req = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (a2d.strt_cnv) break;
        end
        chk("dmd_strt_latency", 32'(n), 32'd2);
        wait_ack_drop(100, "dmd_ack_seen");
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack), 32'd0);
        chk("dmd_res_held", 32'(dmd_res), 32'h105);
        chk("dmd_no_valid", 32'(valid), 32'h05);

        // Demand interleaved into a ch0/ch1 scan
        ch_mask = 8'h03;
        exp_ch.push_back(3'd0);
        exp_ch.push_back(3'd5);
        exp_ch.push_back(3'd1);
        exp_dmd.push_back(12'h105);
        base = sd_cnt;
        ov0 = ovr_cnt;
        en = 1'b1;
        for (int i = 0; i < 300 && exp_ch.size() > 2; i++) @(negedge clk);
        chk("il_ch0_started", 32'(exp_ch.size()), 32'd2);
        repeat (5) @(negedge clk);
        req_ch = 3'd5;
        req = 1'b1;
        wait_ack_drop(200, "il_ack_seen");
        chk("il_no_sd_before_ack", 32'(sd_cnt - base), 32'd0);
        wait_sd(base + 1, 300, "il_scan_done");
        en = 1'b0;
        chk("il_last_ch1", 32'(last_strt_ch), 32'd1);
        chk("il_q_empty", 32'(exp_ch.size() + exp_dmd.size()), 32'd0);
        chk("il_valid_07", 32'(valid), 32'h07);
        read_chk(3'd1, 12'h101, "il_rd_ch1");
        chk("il_overrun_once", 32'(ovr_cnt - ov0), 32'd1);

        // Watchdog timeout, then a normal scan in the next period
        repeat (5) @(negedge clk);
        ch_mask = 8'h08;
        hang = 1'b1;
        exp_ch.push_back(3'd3);
        exp_ch.push_back(3'd3);
        base = sd_cnt;
        ov0 = ovr_cnt;
        ak0 = ack_cnt;
        en = 1'b1;
        wait_strt_now(300, "to_strt_seen");
        early = 0;
        for (int i = 1; i <= TIMEOUT - 1; i++) begin
            @(negedge clk);
            if (err) early++;
        end
        chk("err_not_early", 32'(early), 32'd0);
        @(negedge clk);
        chk("err_at_timeout", 32'(err), 32'd1);
        hang = 1'b0;
        chk("to_no_store", 32'(valid), 32'h07);
        wait_sd(base + 1, 300, "to_next_scan_done");
        en = 1'b0;
        chk("to_valid_0f", 32'(valid), 32'h0F);
        read_chk(3'd3, 12'h103, "to_rd_ch3");
        chk("err_sticky", 32'(err), 32'd1);
        chk("to_q_empty", 32'(exp_ch.size()), 32'd0);
        chk("to_no_overrun", 32'(ovr_cnt - ov0), 32'd0);
        chk("to_no_ack", 32'(ack_cnt - ak0), 32'd0);

        // Overrun: 8-channel scan longer than three periods
        repeat (5) @(negedge clk);
        ch_mask = 8'hFF;
        repeat (2) for (int c = 0; c < 8; c++) exp_ch.push_back(3'(c));
        base = sd_cnt;
        ov0 = ovr_cnt;
        en = 1'b1;
        wait_sd(base + 2, 1200, "ov_two_scans");
        en = 1'b0;
        chk("ov_count", 32'(ovr_cnt - ov0), 32'd6);
        chk("ov_q_empty", 32'(exp_ch.size()), 32'd0);
        chk("ov_valid_ff", 32'(valid), 32'hFF);
        read_chk(3'd7, 12'h107, "ov_rd_ch7");

        // Empty mask: scans are skipped
        repeat (5) @(negedge clk);
        ch_mask = 8'h00;
        base = sd_cnt;
        st0 = strt_cnt;
        ov0 = ovr_cnt;
        en = 1'b1;
        repeat (5 * PERIOD + 20) @(negedge clk);
        en = 1'b0;
        chk("m0_no_strt", 32'(strt_cnt - st0), 32'd0);
        chk("m0_no_sd", 32'(sd_cnt - base), 32'd0);
        chk("m0_no_overrun", 32'(ovr_cnt - ov0), 32'd0);

        // Asynchronous reset in the middle of WAIT
        repeat (5) @(negedge clk);
        ch_mask = 8'h01;
        exp_ch.push_back(3'd0);
        en = 1'b1;
        wait_strt_now(300, "arst_strt_seen");
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        check_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        ak0 = ack_cnt;
        st0 = strt_cnt;
        repeat (60) @(negedge clk);
        chk("arst_stale_cmplt_seen", 32'(a2d.cnv_cmplt), 32'd1);
        chk("arst_no_ack", 32'(ack_cnt - ak0), 32'd0);
        chk("arst_no_strt", 32'(strt_cnt - st0), 32'd0);
        chk("arst_valid_0", 32'(valid), 32'd0);
        read_chk(3'd0, 12'h000, "arst_rd_ch0");
        chk("arst_q_empty", 32'(exp_ch.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
